// File: rtl/exe_pkg.sv
// Shared definitions for the execute-stage bundle scheduler.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: lane op encoding, lane count ceiling, overflow-capable op set.
package exe_pkg;

  localparam int MAX_LANES = 4;
  localparam int OP_W      = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLL  = 4'd6,   // src2 << src1[log2(DW)-1:0]
    OP_SRL  = 4'd7,   // src2 >> src1[log2(DW)-1:0]
    OP_SRA  = 4'd8,   // src2 >>> src1[log2(DW)-1:0]
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MOV1 = 4'd11,  // pass src1
    OP_MOV2 = 4'd12   // pass src2
  } exe_op_e;

  // Ops whose signed result can overflow and report it on out_ov.
  function automatic logic op_has_ov(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/exe_lane_alu.sv
// Single-cycle lane ALU: one op on two DW-bit operands, signed add/sub overflow flag.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is consumed.
// Ports: op (exe_op_e encoding), src1/src2 operands, result, ov (signed overflow).
module exe_lane_alu
  import exe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic [DW-1:0]   src1,
  input  logic [DW-1:0]   src2,
  output logic [DW-1:0]   result,
  output logic            ov
);

  localparam int SHW = $clog2(DW);

  logic [SHW-1:0] shamt;
  logic [DW-1:0]  sum;
  logic [DW-1:0]  diff;
  logic           ov_add;
  logic           ov_sub;

  assign shamt = src1[SHW-1:0];
  assign sum   = src1 + src2;
  assign diff  = src1 - src2;

  // Overflow: operands agree (add) / disagree (sub) in sign and result sign flips.
  assign ov_add = (src1[DW-1] == src2[DW-1]) && (sum[DW-1]  != src1[DW-1]);
  assign ov_sub = (src1[DW-1] != src2[DW-1]) && (diff[DW-1] != src1[DW-1]);
  assign ov     = op_has_ov(op) && ((op == OP_SUB) ? ov_sub : ov_add);

  always_comb begin
    result = '0;
    case (exe_op_e'(op))
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_AND:  result = src1 & src2;
      OP_OR:   result = src1 | src2;
      OP_XOR:  result = src1 ^ src2;
      OP_NOR:  result = ~(src1 | src2);
      OP_SLL:  result = src2 << shamt;
      OP_SRL:  result = src2 >> shamt;
      OP_SRA:  result = $signed(src2) >>> shamt;
      OP_SLT:  result = {{(DW-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLTU: result = {{(DW-1){1'b0}}, (src1 < src2)};
      OP_MOV1: result = src1;
      OP_MOV2: result = src2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exe_bundle_sched.sv
// Execute-stage scheduler for a LANES-wide bundle with intra-bundle dependencies and multicycle lanes.
// Latency: independent single-cycle bundle leaves in its arrival cycle; each dependency level adds one cycle.
// Backpressure: bundle holds (results frozen in res_r) while pms_allowin=0; es_allowin drops until it leaves.
// Ports: clk/reset; ds_to_es_valid/es_allowin + in_* bundle capture; mc_req/mc_src*/mc_done/mc_result/mc_flush
//        to external multicycle units; es_to_pms_valid/pms_allowin + out_result/out_ov downstream;
//        fwd_valid/fwd_ready/fwd_result per-lane bypass; clear_all pipeline flush.
module exe_bundle_sched
  import exe_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // upstream
  input  logic                  ds_to_es_valid,
  output logic                  es_allowin,
  input  logic [LANES-1:0]      in_lane_valid,
  input  logic [LANES*4-1:0]    in_op,
  input  logic [LANES-1:0]      in_mc,
  input  logic [LANES*DW-1:0]   in_src1,
  input  logic [LANES*DW-1:0]   in_src2,
  input  logic [LANES*LANES-1:0] in_dep1,
  input  logic [LANES*LANES-1:0] in_dep2,
  // multicycle units
  output logic [LANES-1:0]      mc_req,
  output logic [LANES*DW-1:0]   mc_src1,
  output logic [LANES*DW-1:0]   mc_src2,
  input  logic [LANES-1:0]      mc_done,
  input  logic [LANES*DW-1:0]   mc_result,
  output logic                  mc_flush,
  // downstream
  output logic                  es_to_pms_valid,
  input  logic                  pms_allowin,
  output logic [LANES*DW-1:0]   out_result,
  output logic [LANES-1:0]      out_ov,
  // forwarding
  output logic [LANES-1:0]      fwd_valid,
  output logic [LANES-1:0]      fwd_ready,
  output logic [LANES*DW-1:0]   fwd_result,
  // flush
  input  logic                  clear_all
);

  // Captured bundle
  logic                              es_valid;
  logic [LANES-1:0]                  lane_vld_r;
  logic [LANES-1:0][3:0]             op_r;
  logic [LANES-1:0]                  mc_r;
  logic [LANES-1:0][DW-1:0]          src1_r;
  logic [LANES-1:0][DW-1:0]          src2_r;
  logic [LANES-1:0][LANES-1:0]       dep1_r;
  logic [LANES-1:0][LANES-1:0]       dep2_r;

  // Per-lane completion state
  logic [LANES-1:0]                  done_r;
  logic [LANES-1:0][DW-1:0]          res_r;
  logic [LANES-1:0]                  ov_r;

  // Combinational lane view
  logic [LANES-1:0][LANES-1:0]       dep1_eff;
  logic [LANES-1:0][LANES-1:0]       dep2_eff;
  logic [LANES-1:0][DW-1:0]          opa;
  logic [LANES-1:0][DW-1:0]          opb;
  logic [LANES-1:0][DW-1:0]          alu_res;
  logic [LANES-1:0]                  alu_ov;
  logic [LANES-1:0][DW-1:0]          mc_res_a;
  logic [LANES-1:0][DW-1:0]          lane_res;
  logic [LANES-1:0]                  lane_ov;
  logic [LANES-1:0][DW-1:0]          out_res_a;
  logic [LANES-1:0]                  deps_met;
  logic [LANES-1:0]                  issuable;
  logic [LANES-1:0]                  complete_now;
  logic                              es_ready_go;
  logic                              capture;
  logic                              leave;

  assign mc_res_a = mc_result;

  // Only backward references to occupied lanes are real dependencies; anything
  // else falls back to the captured operand.
  always_comb begin
    dep1_eff = '0;
    dep2_eff = '0;
    opa      = src1_r;
    opb      = src2_r;
    deps_met = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (j < i) begin
          dep1_eff[i][j] = dep1_r[i][j] & lane_vld_r[j];
          dep2_eff[i][j] = dep2_r[i][j] & lane_vld_r[j];
          if (dep1_eff[i][j]) opa[i] = res_r[j];
          if (dep2_eff[i][j]) opb[i] = res_r[j];
        end
      end
      // Producers must already be registered, so each level costs one cycle.
      deps_met[i] = &(~(dep1_eff[i] | dep2_eff[i]) | done_r);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exe_lane_alu #(.DW(DW)) u_alu (
      .op     (op_r[g]),
      .src1   (opa[g]),
      .src2   (opb[g]),
      .result (alu_res[g]),
      .ov     (alu_ov[g])
    );
  end

  always_comb begin
    issuable     = '0;
    complete_now = '0;
    lane_res     = '0;
    lane_ov      = '0;
    out_res_a    = '0;
    out_ov       = '0;
    for (int i = 0; i < LANES; i++) begin
      issuable[i]     = es_valid & lane_vld_r[i] & ~done_r[i] & deps_met[i];
      complete_now[i] = issuable[i] & (~mc_r[i] | mc_done[i]);
      lane_res[i]     = mc_r[i] ? mc_res_a[i] : alu_res[i];
      lane_ov[i]      = ~mc_r[i] & alu_ov[i];
      // Once registered, the lane shows res_r so outputs stay frozen under backpressure.
      out_res_a[i]    = done_r[i] ? res_r[i] : lane_res[i];
      out_ov[i]       = done_r[i] ? ov_r[i]  : lane_ov[i];
    end
  end

  assign es_ready_go     = &(~lane_vld_r | done_r | complete_now);
  assign es_allowin      = clear_all | ~es_valid | (es_ready_go & pms_allowin);
  assign capture         = ds_to_es_valid & es_allowin & ~clear_all;
  assign leave           = es_valid & es_ready_go & pms_allowin;
  assign es_to_pms_valid = es_valid & es_ready_go & ~clear_all;

  assign mc_req     = issuable & mc_r & {LANES{~clear_all}};
  assign mc_src1    = opa;
  assign mc_src2    = opb;
  assign mc_flush   = clear_all & ~reset;

  assign out_result = out_res_a;
  assign fwd_valid  = {LANES{es_valid}} & lane_vld_r;
  assign fwd_ready  = done_r | complete_now;
  assign fwd_result = out_res_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid   <= 1'b0;
      lane_vld_r <= '0;
      op_r       <= '0;
      mc_r       <= '0;
      src1_r     <= '0;
      src2_r     <= '0;
      dep1_r     <= '0;
      dep2_r     <= '0;
      done_r     <= '0;
      res_r      <= '0;
      ov_r       <= '0;
    end else if (clear_all) begin
      // Any mc_done arriving now belongs to the aborted bundle and is dropped.
      es_valid <= 1'b0;
      done_r   <= '0;
    end else if (capture) begin
      es_valid   <= 1'b1;
      lane_vld_r <= in_lane_valid;
      op_r       <= in_op;
      mc_r       <= in_mc;
      src1_r     <= in_src1;
      src2_r     <= in_src2;
      dep1_r     <= in_dep1;
      dep2_r     <= in_dep2;
      done_r     <= '0;
    end else if (leave) begin
      es_valid <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (complete_now[i]) begin
          done_r[i] <= 1'b1;
          res_r[i]  <= lane_res[i];
          ov_r[i]   <= lane_ov[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_exe_bundle_sched.sv
module tb_exe_bundle_sched;
  import exe_pkg::*;

  localparam int L = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             ds_to_es_valid;
  logic             es_allowin;
  logic [L-1:0]     in_lane_valid;
  logic [L*4-1:0]   in_op;
  logic [L-1:0]     in_mc;
  logic [L*W-1:0]   in_src1, in_src2;
  logic [L*L-1:0]   in_dep1, in_dep2;
  logic [L-1:0]     mc_req;
  logic [L*W-1:0]   mc_src1, mc_src2;
  logic [L-1:0]     mc_done;
  logic [L*W-1:0]   mc_result;
  logic             mc_flush;
  logic             es_to_pms_valid;
  logic             pms_allowin;
  logic [L*W-1:0]   out_result;
  logic [L-1:0]     out_ov;
  logic [L-1:0]     fwd_valid, fwd_ready;
  logic [L*W-1:0]   fwd_result;
  logic             clear_all;

  exe_bundle_sched #(.LANES(L), .DW(W)) dut (
    .clk(clk), .reset(reset),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .in_lane_valid(in_lane_valid), .in_op(in_op), .in_mc(in_mc),
    .in_src1(in_src1), .in_src2(in_src2), .in_dep1(in_dep1), .in_dep2(in_dep2),
    .mc_req(mc_req), .mc_src1(mc_src1), .mc_src2(mc_src2),
    .mc_done(mc_done), .mc_result(mc_result), .mc_flush(mc_flush),
    .es_to_pms_valid(es_to_pms_valid), .pms_allowin(pms_allowin),
    .out_result(out_result), .out_ov(out_ov),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_result(fwd_result),
    .clear_all(clear_all)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [L-1:0]        mask;
    logic [L-1:0][W-1:0] res;
    logic [L-1:0]        ov;
    int                  lat;
  } exp_t;

  exp_t exp_q[$];
  int   cap_q[$];

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: pops the expected bundle whenever a downstream handshake happens.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   c;
    if (!reset) begin
      if (clear_all) cap_q.delete();
      if (es_to_pms_valid && pms_allowin) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=0x%0h required=no output (cycle %0d)", out_result, cyc);
        end else begin
          e = exp_q.pop_front();
          c = (cap_q.size() != 0) ? cap_q.pop_front() : -1000;
          for (int i = 0; i < L; i++)
            if (e.mask[i]) chk($sformatf("result_lane%0d", i), out_result[i*W +: W], e.res[i]);
          chk("out_ov", out_ov & e.mask, e.ov);
          chk("fwd_ready_at_leave", fwd_ready & e.mask, e.mask);
          chk("latency", cyc - c, e.lat);
        end
      end
      if (ds_to_es_valid && es_allowin && !clear_all) cap_q.push_back(cyc);
    end
  end

  task automatic clr_lanes();
    in_lane_valid = '0; in_op = '0; in_mc = '0;
    in_src1 = '0; in_src2 = '0; in_dep1 = '0; in_dep2 = '0;
  endtask

  task automatic set_lane(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [L-1:0] d1, input logic [L-1:0] d2, input logic m);
    in_lane_valid[i]  = 1'b1;
    in_op[i*4 +: 4]   = op;
    in_src1[i*W +: W] = a;
    in_src2[i*W +: W] = b;
    in_dep1[i*L +: L] = d1;
    in_dep2[i*L +: L] = d2;
    in_mc[i]          = m;
  endtask

  task automatic expect_b(input logic [L-1:0] m, input logic [W-1:0] r0, input logic [W-1:0] r1,
                          input logic [W-1:0] r2, input logic [W-1:0] r3, input logic [L-1:0] ov, input int lat);
    exp_t e;
    e.mask = m; e.ov = ov; e.lat = lat;
    e.res[0] = r0; e.res[1] = r1; e.res[2] = r2; e.res[3] = r3;
    exp_q.push_back(e);
  endtask

  // Offers the bundle; returns #1 after the accepting edge (bundle's first cycle in stage).
  task automatic send();
    int n = 0;
    ds_to_es_valid = 1'b1;
    @(negedge clk);
    while (!es_allowin && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", es_allowin, 1);
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ds_to_es_valid = 1'b0; pms_allowin = 1'b1; clear_all = 1'b0;
    mc_done = '0; mc_result = '0;
    clr_lanes();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pms_valid", es_to_pms_valid, 0);
    chk("rst_mc_req", mc_req, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_fwd_ready", fwd_ready, 0);
    chk("rst_mc_flush", mc_flush, 0);
    chk("rst_allowin", es_allowin, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_pms_valid", es_to_pms_valid, 0);

    // Independent bundle: add 3+4, xor F0^FF, leaves in arrival cycle
    @(posedge clk); #1;
    clr_lanes();
    set_lane(0, OP_ADD, 32'd3, 32'd4, '0, '0, 1'b0);
    set_lane(1, OP_XOR, 32'hF0, 32'hFF, '0, '0, 1'b0);
    expect_b(4'b0011, 32'd7, 32'h0F, 32'd0, 32'd0, 4'b0000, 1);
    send();

    // Back-to-back: slt/sltu/sra; self dep and dep on an empty lane ignored
    clr_lanes();
    set_lane(0, OP_SLT,  32'hFFFF_FFFF, 32'd1, '0, '0, 1'b0);
    set_lane(1, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 4'b0010, '0, 1'b0);
    set_lane(3, OP_SRA,  32'd36, 32'h8000_0000, '0, 4'b0100, 1'b0);
    expect_b(4'b1011, 32'd1, 32'd0, 32'd0, 32'hF800_0000, 4'b0000, 1);
    send();
    wait_drain();

    // One dependency level: lane1 = (5+6)+1
    @(posedge clk); #1;
    clr_lanes();
    set_lane(0, OP_ADD, 32'd5, 32'd6, '0, '0, 1'b0);
    set_lane(1, OP_ADD, 32'd0, 32'd1, 4'b0001, '0, 1'b0);
    expect_b(4'b0011, 32'd11, 32'd12, 32'd0, 32'd0, 4'b0000, 2);
    send();
    wait_drain();

    // Four-deep chain, each +1 from 0
    @(posedge clk); #1;
    clr_lanes();
    set_lane(0, OP_ADD, 32'd0, 32'd1, '0, '0, 1'b0);
    for (int i = 1; i < L; i++) set_lane(i, OP_ADD, 32'd0, 32'd1, L'(1 << (i - 1)), '0, 1'b0);
    expect_b(4'b1111, 32'd1, 32'd2, 32'd3, 32'd4, 4'b0000, 4);
    send();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("chain_fwd_ready_c%0d", k), fwd_ready, (1 << k) - 1);
      @(posedge clk); #1;
    end
    wait_drain();

    // Multicycle lane0 done after 5 cycles, lane1 depends on it
    clr_lanes();
    set_lane(0, OP_ADD, 32'hA, 32'hB, '0, '0, 1'b1);
    set_lane(1, OP_ADD, 32'd0, 32'd1, 4'b0001, '0, 1'b0);
    expect_b(4'b0011, 32'h1234, 32'h1235, 32'd0, 32'd0, 4'b0000, 6);
    send();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin
        mc_done[0] = 1'b1;
        mc_result[W-1:0] = 32'h1234;
      end
      @(negedge clk);
      chk($sformatf("mc_req_wait_c%0d", k), mc_req, 4'b0001);
      if (k == 1) chk("mc_src1_lane0", mc_src1[W-1:0], 32'hA);
      @(posedge clk); #1;
      if (k == 5) mc_done = '0;
    end
    @(negedge clk);
    chk("mc_req_after_done", mc_req, 0);
    wait_drain();

    // Overflow plus 3 cycles of downstream backpressure
    @(posedge clk); #1;
    pms_allowin = 1'b0;
    clr_lanes();
    set_lane(0, OP_ADD, 32'h7FFF_FFFF, 32'd1, '0, '0, 1'b0);
    set_lane(1, OP_SUB, 32'h8000_0000, 32'd1, '0, '0, 1'b0);
    expect_b(4'b0011, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0, 4'b0011, 4);
    send();
    clr_lanes();
    set_lane(0, OP_XOR, 32'h5555_5555, 32'h1, '0, '0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold_valid_c%0d", k), es_to_pms_valid, 1);
      chk($sformatf("hold_res0_c%0d", k), out_result[W-1:0], 32'h8000_0000);
      chk($sformatf("hold_ov_c%0d", k), out_ov, 4'b0011);
      chk($sformatf("hold_allowin_c%0d", k), es_allowin, 0);
      @(posedge clk); #1;
    end
    pms_allowin = 1'b1;
    wait_drain();

    // clear_all while waiting on a multicycle op; late mc_done and offered bundle dropped
    @(posedge clk); #1;
    clr_lanes();
    set_lane(0, OP_ADD, 32'd1, 32'd2, '0, '0, 1'b1);
    send();
    @(negedge clk);
    chk("flush_mc_req_wait", mc_req, 4'b0001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_all = 1'b1;
    mc_done[0] = 1'b1;
    mc_result[W-1:0] = 32'hDEAD;
    clr_lanes();
    set_lane(0, OP_ADD, 32'd9, 32'd9, '0, '0, 1'b0);
    ds_to_es_valid = 1'b1;
    @(negedge clk);
    chk("flush_mc_flush", mc_flush, 1);
    chk("flush_pms_valid", es_to_pms_valid, 0);
    chk("flush_allowin", es_allowin, 1);
    @(posedge clk); #1;
    clear_all = 1'b0;
    mc_done = '0;
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_fwd_valid", fwd_valid, 0);
    chk("post_flush_mc_req", mc_req, 0);
    chk("post_flush_mc_flush", mc_flush, 0);
    repeat (3) @(negedge clk);

    // Recovery after flush
    @(posedge clk); #1;
    clr_lanes();
    set_lane(0, OP_SUB, 32'd10, 32'd3, '0, '0, 1'b0);
    expect_b(4'b0001, 32'd7, 32'd0, 32'd0, 32'd0, 4'b0000, 1);
    send();
    wait_drain();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
